axi4_lite_cmd_master: RTL

Parametrised AXI4-Lite master that turns one command at a time from a valid/ready command port into a full AXI4-Lite read or write. It drives the AW and W channels independently, uses per-command byte strobes, and returns the captured RDATA/RRESP/BRESP on a valid/ready response port. It also keeps a saturating error counter. It sits between on-chip control logic (CPU bridge, register sequencer) and any AXI4-Lite slave in the design.

---
 rtl/axi4_lite_cmd_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite master: executes one read or write command at a time from a valid/ready
// command port and returns the captured response, counting non-OKAY responses.
module axi4_lite_cmd_master #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [2:0]  PROT          = 3'b000,
    parameter int          ERR_CNT_WIDTH = 16,
    localparam int         STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic                     CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]    CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]    CMD_WDATA,
    input  logic [STRB_WIDTH-1:0]    CMD_WSTRB,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic                     RSP_WRITE,
    output logic [DATA_WIDTH-1:0]    RSP_RDATA,
    output logic [1:0]               RSP_RESP,
    output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT,
    output logic [ADDR_WIDTH-1:0]    M_AWADDR,
    output logic [2:0]               M_AWPROT,
    output logic                     M_AWVALID,
    input  logic                     M_AWREADY,
    output logic [DATA_WIDTH-1:0]    M_WDATA,
    output logic [STRB_WIDTH-1:0]    M_WSTRB,
    output logic                     M_WVALID,
    input  logic                     M_WREADY,
    input  logic [1:0]               M_BRESP,
    input  logic                     M_BVALID,
    output logic                     M_BREADY,
    output logic [ADDR_WIDTH-1:0]    M_ARADDR,
    output logic [2:0]               M_ARPROT,
    output logic                     M_ARVALID,
    input  logic                     M_ARREADY,
    input  logic [DATA_WIDTH-1:0]    M_RDATA,
    input  logic [1:0]               M_RRESP,
    input  logic                     M_RVALID,
    output logic                     M_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t state;

    assign CMD_READY = (state == IDLE);
    assign M_AWPROT  = PROT;
    assign M_ARPROT  = PROT;

    // AW and W are each "done" once their VALID is low or being accepted this edge,
    // so the two channels may finish in either order or together.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WRITE <= 1'b0;
            RSP_RDATA <= '0;
            RSP_RESP  <= 2'b00;
            ERR_COUNT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        if (CMD_WRITE) begin
                            M_AWADDR  <= CMD_ADDR;
                            M_WDATA   <= CMD_WDATA;
                            M_WSTRB   <= CMD_WSTRB;
                            M_AWVALID <= 1'b1;
                            M_WVALID  <= 1'b1;
                            state     <= WR;
                        end else begin
                            M_ARADDR  <= CMD_ADDR;
                            M_ARVALID <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (M_AWVALID && M_AWREADY) M_AWVALID <= 1'b0;
                    if (M_WVALID && M_WREADY)   M_WVALID  <= 1'b0;
                    if ((!M_AWVALID || M_AWREADY) && (!M_WVALID || M_WREADY)) begin
                        M_BREADY <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_BVALID) begin
                        M_BREADY  <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b1;
                        RSP_RDATA <= '0;
                        RSP_RESP  <= M_BRESP;
                        if (M_BRESP != 2'b00 && ERR_COUNT != '1)
                            ERR_COUNT <= ERR_COUNT + ERR_CNT_WIDTH'(1);
                        state     <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_RVALID) begin
                        M_RREADY  <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b0;
                        RSP_RDATA <= M_RDATA;
                        RSP_RESP  <= M_RRESP;
                        if (M_RRESP != 2'b00 && ERR_COUNT != '1)
                            ERR_COUNT <= ERR_COUNT + ERR_CNT_WIDTH'(1);
                        state     <= RSP;
                    end
                end
                RSP: begin
                    // Address/data buses return to zero once the command is fully retired.
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        M_AWADDR  <= '0;
                        M_WDATA   <= '0;
                        M_WSTRB   <= '0;
                        M_ARADDR  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
